// File: rtl/sig_viterbi_dec.sv
// K=7 rate-1/2 (133/171) hard-decision Viterbi decoder, register-exchange survivors.
// Optional final-metric output port: define VDEC_METRIC_EN.
module sig_viterbi_dec #(
  parameter int N_BITS = 24,
  parameter int PM_W   = 7
) (
  input  logic            sce_clk,
  input  logic            sce_rst_n,
  input  logic            vdec_clr,
  input  logic [1:0]      vdec_di,
  input  logic            vdec_di_vld,
  output logic            vdec_di_rdy,
  output logic            vdec_do,
  output logic            vdec_do_vld,
`ifdef VDEC_METRIC_EN
  output logic [PM_W-1:0] vdec_metric,
`endif
  output logic            vdec_done
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 1);
  localparam logic [CW-1:0]   CNT_END = CW'(N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACS  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PM_W-1:0]   pm_q   [64];
  logic [PM_W-1:0]   pm_n   [64];
  logic [N_BITS-1:0] surv_q [64];
  logic [N_BITS-1:0] surv_n [64];
  logic [N_BITS-1:0] sr_q;
  logic [CW-1:0]     cnt_q;

  logic accept;
  logic last_in;
  logic last_out;

  function automatic logic [1:0] ham(input logic [1:0] x);
    ham = {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sadd(
    input logic [PM_W-1:0] a,
    input logic [1:0]      bm
  );
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, bm};
    sadd = s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  assign accept   = vdec_di_vld & vdec_di_rdy;
  assign last_in  = accept & (cnt_q == CNT_END);
  assign last_out = (state_q == S_OUT) & (cnt_q == CNT_END);

  // One ACS butterfly per next-state; ties resolve to the p0 predecessor.
  for (genvar g = 0; g < 64; g++) begin : g_acs
    localparam logic [5:0] NS = 6'(g);
    localparam logic [5:0] P0 = {1'b0, NS[5:1]};
    localparam logic [5:0] P1 = {1'b1, NS[5:1]};
    localparam logic [1:0] E0 = {
      NS[0] ^ P0[1] ^ P0[2] ^ P0[4] ^ P0[5],
      NS[0] ^ P0[0] ^ P0[1] ^ P0[2] ^ P0[5]};
    localparam logic [1:0] E1 = {
      NS[0] ^ P1[1] ^ P1[2] ^ P1[4] ^ P1[5],
      NS[0] ^ P1[0] ^ P1[1] ^ P1[2] ^ P1[5]};
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;
    logic            sel1;
    assign c0   = sadd(pm_q[P0], ham(vdec_di ^ E0));
    assign c1   = sadd(pm_q[P1], ham(vdec_di ^ E1));
    assign sel1 = c1 < c0;
    assign pm_n[g]   = sel1 ? c1 : c0;
    assign surv_n[g] = sel1 ?
      {surv_q[P1][N_BITS-2:0], NS[0]} :
      {surv_q[P0][N_BITS-2:0], NS[0]};
  end

  always_ff @(posedge sce_clk or negedge sce_rst_n) begin
    if (!sce_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = last_in ? S_OUT : S_ACS;
      S_ACS:   if (last_in) state_d = S_OUT;
      S_OUT:   if (last_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (vdec_clr) state_d = S_IDLE;
  end

  always_ff @(posedge sce_clk or negedge sce_rst_n) begin
    if (!sce_rst_n) begin
      for (int i = 0; i < 64; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (vdec_clr || last_out) begin
      for (int i = 0; i < 64; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 64; i++) begin
        pm_q[i]   <= pm_n[i];
        surv_q[i] <= surv_n[i];
      end
      cnt_q <= last_in ? '0 : cnt_q + 1'b1;
      if (last_in) sr_q <= surv_n[0];
    end else if (state_q == S_OUT) begin
      sr_q  <= sr_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef VDEC_METRIC_EN
  logic [PM_W-1:0] metric_q;

  always_ff @(posedge sce_clk or negedge sce_rst_n) begin
    if (!sce_rst_n)    metric_q <= '0;
    else if (vdec_clr) metric_q <= '0;
    else if (last_in)  metric_q <= pm_n[0];
  end

  assign vdec_metric = metric_q;
`endif

  assign vdec_di_rdy = (state_q != S_OUT);
  assign vdec_do_vld = (state_q == S_OUT);
  assign vdec_do     = vdec_do_vld & sr_q[N_BITS-1];
  assign vdec_done   = last_out;

endmodule
